// File: rtl/led_matrix_receiver_pkg.sv
// Shared constants and FSM encoding for the SPI-fed LED matrix receiver.
// Both the byte shifter and the control top import this package.
package led_matrix_receiver_pkg;

  localparam logic [7:0] CMD_RESET_FRAME_INDEX = 8'h26;
  localparam logic [5:0] PIXEL_MAX             = 6'h3f;
  localparam logic [2:0] BIT_LAST              = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_END  = 2'd2
  } state_e;

  // A frame is a command only when it carried exactly one byte and that byte is the opcode.
  function automatic logic is_cmd_frame(input logic [1:0] count, input logic [7:0] value);
    return (count == 2'd1) && (value == CMD_RESET_FRAME_INDEX);
  endfunction

endpackage

// File: rtl/spi_rx_shifter.sv
// SPI mode-0 receive front end: synchronizes sclk/mosi/n_cs into the clock domain,
// detects edges and assembles MSB-first bytes. All outputs are single-cycle strobes.
module spi_rx_shifter
  import led_matrix_receiver_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       n_cs,
  output logic       byte_done,
  output logic [7:0] data_byte,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       partial
);

  logic [2:0] sclk_s;
  logic [2:0] cs_s;
  logic [1:0] mosi_s;
  logic       live;
  logic       armed;
  logic       in_frame;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       sclk_rise;
  logic       fall_raw;
  logic       rise_raw;
  logic       shift;

  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_s <= 3'b000;
      mosi_s <= 2'b00;
      cs_s   <= 3'b111;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk};
      mosi_s <= {mosi_s[0], mosi};
      cs_s   <= {cs_s[1:0], n_cs};
    end
  end

  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign fall_raw  = ~cs_s[1] & cs_s[2];
  assign rise_raw  = cs_s[1] & ~cs_s[2];

  // A frame is only accepted after n_cs has been seen high since reset, so a
  // reset in mid-frame drops the rest of that frame.
  assign cs_fall   = armed & fall_raw;
  assign cs_rise   = in_frame & rise_raw;
  assign shift     = in_frame & sclk_rise;
  assign data_byte = {shreg[6:0], mosi_s[1]};
  assign byte_done = shift && (bit_cnt == BIT_LAST);

  // A byte finishing on the same cycle as n_cs rising is not a partial byte.
  always_comb begin
    partial = 1'b0;
    if (cs_rise) begin
      if (shift) partial = (bit_cnt != BIT_LAST);
      else       partial = (bit_cnt != 3'd0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      live     <= 1'b0;
      armed    <= 1'b0;
      in_frame <= 1'b0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
    end else begin
      live <= 1'b1;
      // Stage 1 holds its reset value for one cycle, so wait until it reflects the pin.
      if (live && cs_s[0]) armed <= 1'b1;
      if (shift) shreg <= data_byte;
      if (cs_fall) begin
        in_frame <= 1'b1;
        bit_cnt  <= 3'd0;
      end else if (cs_rise) begin
        in_frame <= 1'b0;
        bit_cnt  <= 3'd0;
      end else if (shift) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/led_matrix_receiver.sv
// Control top: turns received SPI bytes into pixel writes with a one-byte hold-back,
// so a lone 0x26 frame can be recognised as the reset-frame-index command.
module led_matrix_receiver
  import led_matrix_receiver_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       n_cs,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       pix_we,
  output logic [5:0] pix_addr,
  output logic [7:0] pix_data,
  output logic       cmd_rfi,
  output logic       frame_done,
  output logic       rx_abort,
  output state_e     fsm_state
);

  logic       byte_done;
  logic [7:0] data_byte;
  logic       cs_fall;
  logic       cs_rise;
  logic       partial;

  spi_rx_shifter u_shifter (
    .clock     (clock),
    .reset     (reset),
    .sclk      (sclk),
    .mosi      (mosi),
    .n_cs      (n_cs),
    .byte_done (byte_done),
    .data_byte (data_byte),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .partial   (partial)
  );

  state_e     state;
  state_e     state_next;
  logic       ev_done;
  logic       ev_fall;
  logic       ev_rise;
  logic       ev_partial;
  logic       abort_pend;
  logic [7:0] rx_byte_q;
  logic       held_valid;
  logic [7:0] held_byte;
  logic [1:0] byte_cnt;
  logic [5:0] pix_idx;
  logic       wr;
  logic       rfi;
  logic       abort;

  // Events are registered so a byte completing with n_cs rising is handled in RX,
  // one cycle before END flushes the byte it just produced.
  always_ff @(posedge clock) begin
    if (reset) begin
      ev_done    <= 1'b0;
      ev_fall    <= 1'b0;
      ev_rise    <= 1'b0;
      ev_partial <= 1'b0;
      abort_pend <= 1'b0;
      rx_byte_q  <= 8'h00;
    end else begin
      ev_done    <= byte_done;
      ev_fall    <= cs_fall;
      ev_rise    <= cs_rise;
      ev_partial <= partial;
      abort_pend <= ev_rise & ev_partial;
      if (byte_done) rx_byte_q <= data_byte;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (ev_fall) state_next = ST_RX;
      ST_RX:   if (ev_rise) state_next = ST_END;
      ST_END:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wr    = 1'b0;
    rfi   = 1'b0;
    abort = 1'b0;
    if (state == ST_END) begin
      abort = abort_pend;
      if (is_cmd_frame(byte_cnt, held_byte)) rfi = 1'b1;
      else                                   wr  = held_valid;
    end else if (ev_done) begin
      wr = held_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      held_valid <= 1'b0;
      held_byte  <= 8'h00;
      byte_cnt   <= 2'd0;
      pix_idx    <= 6'd0;
    end else begin
      if (state == ST_END) begin
        held_valid <= 1'b0;
        held_byte  <= 8'h00;
        byte_cnt   <= 2'd0;
      end else if (ev_done) begin
        held_valid <= 1'b1;
        held_byte  <= rx_byte_q;
        if (byte_cnt != 2'd2) byte_cnt <= byte_cnt + 2'd1;
      end
      if (rfi)     pix_idx <= 6'd0;
      else if (wr) pix_idx <= pix_idx + 6'd1;
    end
  end

  assign rx_valid   = ev_done;
  assign rx_byte    = rx_byte_q;
  assign pix_we     = wr;
  assign pix_addr   = pix_idx;
  assign pix_data   = wr ? held_byte : 8'h00;
  assign frame_done = wr && (pix_idx == PIXEL_MAX);
  assign cmd_rfi    = rfi;
  assign rx_abort   = abort;
  assign fsm_state  = state;

endmodule

// File: tb/tb_led_matrix_receiver.sv
// Directed bench for led_matrix_receiver: SPI frames driven bit by bit, outputs logged
// on the falling clock edge and compared with hand-computed write lists and counts.
module tb_led_matrix_receiver;
  import led_matrix_receiver_pkg::*;

  logic       clock;
  logic       reset;
  logic       sclk;
  logic       mosi;
  logic       n_cs;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       pix_we;
  logic [5:0] pix_addr;
  logic [7:0] pix_data;
  logic       cmd_rfi;
  logic       frame_done;
  logic       rx_abort;
  state_e     fsm_state;

  led_matrix_receiver dut (
    .clock      (clock),
    .reset      (reset),
    .sclk       (sclk),
    .mosi       (mosi),
    .n_cs       (n_cs),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .pix_we     (pix_we),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .cmd_rfi    (cmd_rfi),
    .frame_done (frame_done),
    .rx_abort   (rx_abort),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks;
  int n_pass;

  // monitor: everything the DUT reports, sampled on the falling edge
  logic [13:0] got_wr_q[$];
  logic [13:0] exp_q[$];
  int          n_rx;
  int          n_cmd;
  int          n_abort;
  int          n_fd;
  logic [7:0]  last_rx;
  logic [5:0]  fd_addr;
  state_e      last_wr_state;
  state_e      last_cmd_state;
  state_e      last_abort_state;

  initial begin
    n_rx = 0; n_cmd = 0; n_abort = 0; n_fd = 0;
    last_rx = 8'h00; fd_addr = 6'd0;
    last_wr_state = ST_IDLE; last_cmd_state = ST_IDLE; last_abort_state = ST_IDLE;
  end

  always @(negedge clock) begin
    if (rx_valid) begin
      n_rx++;
      last_rx = rx_byte;
    end
    if (pix_we) begin
      got_wr_q.push_back({pix_addr, pix_data});
      last_wr_state = fsm_state;
    end
    if (frame_done) begin
      n_fd++;
      fd_addr = pix_addr;
    end
    if (cmd_rfi) begin
      n_cmd++;
      last_cmd_state = fsm_state;
    end
    if (rx_abort) begin
      n_abort++;
      last_abort_state = fsm_state;
    end
  end

  // driver tasks: sclk half period = 4 clocks, changes land on falling clock edges
  task automatic spi_start();
    n_cs = 1'b0;
    #80;
  endtask

  task automatic spi_bits(input logic [7:0] value, input int nbits, input bit cs_on_last);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = value[i];
      #40;
      sclk = 1'b1;
      if (cs_on_last && i == 8 - nbits) n_cs = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic spi_end();
    #40;
    n_cs = 1'b1;
    #200;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else n_pass++;
    n_checks++; if (rx_byte !== 8'h00) $display("FAIL reset_rx_byte: got %h want 00", rx_byte); else n_pass++;
    n_checks++; if (pix_we !== 1'b0) $display("FAIL reset_pix_we: got %b want 0", pix_we); else n_pass++;
    n_checks++; if (pix_addr !== 6'd0) $display("FAIL reset_pix_addr: got %0d want 0", pix_addr); else n_pass++;
    n_checks++; if (pix_data !== 8'h00) $display("FAIL reset_pix_data: got %h want 00", pix_data); else n_pass++;
    n_checks++; if ({cmd_rfi, frame_done, rx_abort} !== 3'b000)
      $display("FAIL reset_pulses: got %b want 000", {cmd_rfi, frame_done, rx_abort}); else n_pass++;
    n_checks++; if (fsm_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", fsm_state, ST_IDLE); else n_pass++;
    reset = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_empty();
    int w0 = got_wr_q.size();
    int r0 = n_rx;
    int c0 = n_cmd;
    int a0 = n_abort;
    spi_start();
    spi_end();
    n_checks++; if (got_wr_q.size() - w0 !== 0) $display("FAIL empty_writes: got %0d want 0", got_wr_q.size() - w0); else n_pass++;
    n_checks++; if ((n_rx - r0) + (n_cmd - c0) + (n_abort - a0) !== 0)
      $display("FAIL empty_pulses: got %0d want 0", (n_rx - r0) + (n_cmd - c0) + (n_abort - a0)); else n_pass++;
    n_checks++; if (fsm_state !== ST_IDLE) $display("FAIL empty_state: got %0d want %0d", fsm_state, ST_IDLE); else n_pass++;
  endtask

  task automatic test_cmd();
    int w0 = got_wr_q.size();
    int r0 = n_rx;
    int c0 = n_cmd;
    spi_start();
    spi_bits(8'h26, 8, 1'b0);
    spi_end();
    n_checks++; if (n_rx - r0 !== 1) $display("FAIL cmd_rx_count: got %0d want 1", n_rx - r0); else n_pass++;
    n_checks++; if (last_rx !== 8'h26) $display("FAIL cmd_rx_byte: got %h want 26", last_rx); else n_pass++;
    n_checks++; if (n_cmd - c0 !== 1) $display("FAIL cmd_rfi_count: got %0d want 1", n_cmd - c0); else n_pass++;
    n_checks++; if (last_cmd_state !== ST_END) $display("FAIL cmd_rfi_state: got %0d want %0d", last_cmd_state, ST_END); else n_pass++;
    n_checks++; if (got_wr_q.size() - w0 !== 0) $display("FAIL cmd_writes: got %0d want 0", got_wr_q.size() - w0); else n_pass++;
  endtask

  task automatic test_full_frame();
    int w0 = got_wr_q.size();
    int f0 = n_fd;
    logic [7:0] value;
    exp_q.delete();
    spi_start();
    for (int k = 0; k < 64; k++) begin
      value = 8'(k);
      spi_bits(value, 8, 1'b0);
      exp_q.push_back({6'(k), value});
    end
    spi_end();
    n_checks++; if (got_wr_q.size() - w0 !== 64) $display("FAIL full_count: got %0d want 64", got_wr_q.size() - w0); else n_pass++;
    for (int k = 0; k < 64; k++) begin
      n_checks++; if (got_wr_q[w0 + k] !== exp_q[k])
        $display("FAIL full_write[%0d]: got %h want %h", k, got_wr_q[w0 + k], exp_q[k]); else n_pass++;
    end
    n_checks++; if (last_wr_state !== ST_END) $display("FAIL full_last_in_end: got %0d want %0d", last_wr_state, ST_END); else n_pass++;
    n_checks++; if (n_fd - f0 !== 1) $display("FAIL full_frame_done_count: got %0d want 1", n_fd - f0); else n_pass++;
    n_checks++; if (fd_addr !== 6'd63) $display("FAIL full_frame_done_addr: got %0d want 63", fd_addr); else n_pass++;
    n_checks++; if (pix_addr !== 6'd0) $display("FAIL full_index_wrap: got %0d want 0", pix_addr); else n_pass++;
  endtask

  task automatic test_single();
    int w0 = got_wr_q.size();
    int c0 = n_cmd;
    spi_start();
    spi_bits(8'h25, 8, 1'b0);
    spi_end();
    n_checks++; if (got_wr_q.size() - w0 !== 1) $display("FAIL single_count: got %0d want 1", got_wr_q.size() - w0); else n_pass++;
    n_checks++; if (got_wr_q[w0] !== {6'd0, 8'h25}) $display("FAIL single_write: got %h want %h", got_wr_q[w0], {6'd0, 8'h25}); else n_pass++;
    n_checks++; if (last_wr_state !== ST_END) $display("FAIL single_in_end: got %0d want %0d", last_wr_state, ST_END); else n_pass++;
    n_checks++; if (n_cmd - c0 !== 0) $display("FAIL single_no_cmd: got %0d want 0", n_cmd - c0); else n_pass++;
  endtask

  task automatic test_double_cmd();
    int w0 = got_wr_q.size();
    int c0 = n_cmd;
    spi_start();
    spi_bits(8'h26, 8, 1'b0);
    spi_bits(8'h26, 8, 1'b0);
    spi_end();
    n_checks++; if (got_wr_q.size() - w0 !== 2) $display("FAIL double_count: got %0d want 2", got_wr_q.size() - w0); else n_pass++;
    n_checks++; if (got_wr_q[w0] !== {6'd1, 8'h26}) $display("FAIL double_write0: got %h want %h", got_wr_q[w0], {6'd1, 8'h26}); else n_pass++;
    n_checks++; if (got_wr_q[w0 + 1] !== {6'd2, 8'h26}) $display("FAIL double_write1: got %h want %h", got_wr_q[w0 + 1], {6'd2, 8'h26}); else n_pass++;
    n_checks++; if (n_cmd - c0 !== 0) $display("FAIL double_no_cmd: got %0d want 0", n_cmd - c0); else n_pass++;
  endtask

  task automatic test_abort();
    int w0 = got_wr_q.size();
    int a0 = n_abort;
    spi_start();
    spi_bits(8'h11, 8, 1'b0);
    spi_bits(8'hFF, 5, 1'b0);
    spi_end();
    n_checks++; if (got_wr_q.size() - w0 !== 1) $display("FAIL abort_count: got %0d want 1", got_wr_q.size() - w0); else n_pass++;
    n_checks++; if (got_wr_q[w0] !== {6'd3, 8'h11}) $display("FAIL abort_write: got %h want %h", got_wr_q[w0], {6'd3, 8'h11}); else n_pass++;
    n_checks++; if (n_abort - a0 !== 1) $display("FAIL abort_pulses: got %0d want 1", n_abort - a0); else n_pass++;
    n_checks++; if (last_abort_state !== ST_END) $display("FAIL abort_state: got %0d want %0d", last_abort_state, ST_END); else n_pass++;
    spi_start();
    spi_bits(8'h5A, 8, 1'b0);
    spi_end();
    n_checks++; if (last_rx !== 8'h5A) $display("FAIL abort_next_rx: got %h want 5a", last_rx); else n_pass++;
    n_checks++; if (got_wr_q[w0 + 1] !== {6'd4, 8'h5A}) $display("FAIL abort_next_write: got %h want %h", got_wr_q[w0 + 1], {6'd4, 8'h5A}); else n_pass++;
  endtask

  // last sclk rise and n_cs rise land on the same clock edge
  task automatic test_back_to_back();
    int w0 = got_wr_q.size();
    int r0 = n_rx;
    int a0 = n_abort;
    spi_start();
    spi_bits(8'h77, 8, 1'b0);
    spi_bits(8'h88, 8, 1'b1);
    spi_end();
    n_checks++; if (n_rx - r0 !== 2) $display("FAIL b2b_rx_count: got %0d want 2", n_rx - r0); else n_pass++;
    n_checks++; if (got_wr_q.size() - w0 !== 2) $display("FAIL b2b_count: got %0d want 2", got_wr_q.size() - w0); else n_pass++;
    n_checks++; if (got_wr_q[w0] !== {6'd5, 8'h77}) $display("FAIL b2b_write0: got %h want %h", got_wr_q[w0], {6'd5, 8'h77}); else n_pass++;
    n_checks++; if (got_wr_q[w0 + 1] !== {6'd6, 8'h88}) $display("FAIL b2b_write1: got %h want %h", got_wr_q[w0 + 1], {6'd6, 8'h88}); else n_pass++;
    n_checks++; if (n_abort - a0 !== 0) $display("FAIL b2b_no_abort: got %0d want 0", n_abort - a0); else n_pass++;
  endtask

  task automatic test_cmd_clear();
    int w0 = got_wr_q.size();
    int c0 = n_cmd;
    spi_start();
    spi_bits(8'h26, 8, 1'b0);
    spi_end();
    n_checks++; if (n_cmd - c0 !== 1) $display("FAIL clear_cmd: got %0d want 1", n_cmd - c0); else n_pass++;
    spi_start();
    spi_bits(8'hC3, 8, 1'b0);
    spi_end();
    n_checks++; if (got_wr_q.size() - w0 !== 1) $display("FAIL clear_count: got %0d want 1", got_wr_q.size() - w0); else n_pass++;
    n_checks++; if (got_wr_q[w0] !== {6'd0, 8'hC3}) $display("FAIL clear_write: got %h want %h", got_wr_q[w0], {6'd0, 8'hC3}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w0;
    int r0;
    spi_start();
    spi_bits(8'h33, 8, 1'b0);
    spi_bits(8'hF0, 3, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++; if ({rx_valid, pix_we, cmd_rfi, frame_done, rx_abort} !== 5'b00000)
      $display("FAIL midreset_pulses: got %b want 00000", {rx_valid, pix_we, cmd_rfi, frame_done, rx_abort}); else n_pass++;
    n_checks++; if ({rx_byte, pix_addr, pix_data} !== 22'd0)
      $display("FAIL midreset_values: got %h want 0", {rx_byte, pix_addr, pix_data}); else n_pass++;
    n_checks++; if (fsm_state !== ST_IDLE) $display("FAIL midreset_state: got %0d want %0d", fsm_state, ST_IDLE); else n_pass++;
    reset = 1'b0;
    w0 = got_wr_q.size();
    r0 = n_rx;
    spi_bits(8'hAB, 8, 1'b0);
    spi_bits(8'hCD, 8, 1'b0);
    spi_end();
    n_checks++; if (got_wr_q.size() - w0 !== 0) $display("FAIL midreset_writes: got %0d want 0", got_wr_q.size() - w0); else n_pass++;
    n_checks++; if (n_rx - r0 !== 0) $display("FAIL midreset_rx: got %0d want 0", n_rx - r0); else n_pass++;
    spi_start();
    spi_bits(8'h44, 8, 1'b0);
    spi_end();
    n_checks++; if (got_wr_q.size() - w0 !== 1) $display("FAIL midreset_next_count: got %0d want 1", got_wr_q.size() - w0); else n_pass++;
    n_checks++; if (got_wr_q[w0] !== {6'd0, 8'h44}) $display("FAIL midreset_next_write: got %h want %h", got_wr_q[w0], {6'd0, 8'h44}); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    n_cs = 1'b1;
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_empty();
    test_cmd();
    test_full_frame();
    test_single();
    test_double_cmd();
    test_abort();
    test_back_to_back();
    test_cmd_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
